// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch / program-counter stage for the multi-cycle controller.
// Owns PC, IR, TR and DI. Turns controller commands into memory reads and
// raises `stall` while the memory is inserting wait states.
// Optional feature macro: FETCH_TIMEOUT_EN (WAIT-state timeout with sticky
// bus_err and force-completion of the stuck access).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter int AW      = 13,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pcInc,
  input  logic          PcOrTR,
  input  logic          irWriteEn,
  input  logic          trWriteEn,
  input  logic          diLoadEn,
  input  logic          pcLoadEn,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          stall,
  output logic [3:0]    IrToCU,
  output logic [4:0]    DiToCU,
  output logic [DW-1:0] ir_out,
  output logic [DW-1:0] tr_out,
  output logic [AW-1:0] pc_out,
  output logic          bus_err
);

  // Wait counter is wide enough to hold TIMEOUT and saturates at all-ones.
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] tr_q, tr_d;
  logic [4:0]    di_q, di_d;

  logic          rd_cmd;
  logic          timeout;
  logic          complete;
  logic [DW-1:0] rdata_eff;
  logic [AW-1:0] jump_tgt;
  logic          pc_step;

  assign rd_cmd   = irWriteEn | trWriteEn;
  assign jump_tgt = {ir_q[4:0], tr_q};

`ifdef FETCH_TIMEOUT_EN
  logic bus_err_q;

  // Abort only while the access is still pending and memory has not answered.
  assign timeout = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT)) && rd_cmd && !mem_ready;

  // Sticky bus error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_err_q <= 1'b0;
    else if (timeout) bus_err_q <= 1'b1;
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // A timed-out access completes with zero data so the controller can proceed.
  assign rdata_eff = mem_ready ? mem_rdata : '0;
  assign complete  = rd_cmd & (mem_ready | timeout);

  assign mem_rd   = rd_cmd;
  assign mem_addr = PcOrTR ? pc_q : jump_tgt;
  assign stall    = rd_cmd & ~mem_ready & ~timeout;

  // Wait-state tracking: IDLE handles zero-wait reads, WAIT counts wait cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_cmd && !complete) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (!rd_cmd || complete) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Architectural register updates; a jump load beats increment, IR load beats DI load.
  always_comb begin
    ir_d    = ir_q;
    tr_d    = tr_q;
    di_d    = di_q;
    pc_step = pcInc & (~rd_cmd | complete);

    if (complete && irWriteEn) begin
      ir_d = rdata_eff;
      di_d = rdata_eff[4:0];
    end else begin
      if (complete && trWriteEn) tr_d = rdata_eff;
      if (diLoadEn) di_d = ir_q[4:0];
    end

    if (pcLoadEn)     pc_d = jump_tgt;
    else if (pc_step) pc_d = pc_q + 1'b1;
    else              pc_d = pc_q;
  end

  // State and register file update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      tr_q    <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      di_q    <= di_d;
    end
  end

  assign IrToCU = ir_q[DW-1:DW-4];
  assign DiToCU = di_q;
  assign ir_out = ir_q;
  assign tr_out = tr_q;
  assign pc_out = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit: each read pushes its expected
// post-completion register state; a monitor pops it when the DUT accepts
// the read (mem_rd & ~stall) and compares one cycle later.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcInc, PcOrTR, irWriteEn, trWriteEn, diLoadEn, pcLoadEn;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [12:0] mem_addr;
  logic        mem_rd, stall;
  logic [3:0]  IrToCU;
  logic [4:0]  DiToCU;
  logic [7:0]  ir_out, tr_out;
  logic [12:0] pc_out;
  logic        bus_err;

  typedef struct packed {
    logic [7:0]  ir;
    logic [7:0]  tr;
    logic [12:0] pc;
    logic [4:0]  di;
    logic        be;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic pend   = 1'b0;

  fetch_unit #(.AW(13), .DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pcInc(pcInc), .PcOrTR(PcOrTR),
    .irWriteEn(irWriteEn), .trWriteEn(trWriteEn), .diLoadEn(diLoadEn),
    .pcLoadEn(pcLoadEn), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .stall(stall), .IrToCU(IrToCU),
    .DiToCU(DiToCU), .ir_out(ir_out), .tr_out(tr_out), .pc_out(pc_out),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: an accepted read is compared against the scoreboard on the next negedge.
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ir_out",  {24'd0, ir_out},  {24'd0, e.ir});
        chk("IrToCU",  {28'd0, IrToCU},  {28'd0, e.ir[7:4]});
        chk("tr_out",  {24'd0, tr_out},  {24'd0, e.tr});
        chk("pc_out",  {19'd0, pc_out},  {19'd0, e.pc});
        chk("DiToCU",  {27'd0, DiToCU},  {27'd0, e.di});
        chk("bus_err", {31'd0, bus_err}, {31'd0, e.be});
      end
    end
    pend = !rst && mem_rd && !stall;
  end

  task automatic idle_cmds();
    irWriteEn = 0; trWriteEn = 0; pcInc = 0; PcOrTR = 1;
    diLoadEn = 0; pcLoadEn = 0; mem_ready = 0; mem_rdata = 8'h00;
  endtask

  // Issue one read with `waits` wait states; entered and left at posedge+1.
  task automatic do_read(input logic ir, input logic tr, input logic inc, input logic sel,
                         input logic di, input logic [7:0] data, input int waits,
                         input logic [12:0] addr, input exp_t e);
    int sc;
    sc = 0;
    sb.push_back(e);
    irWriteEn = ir; trWriteEn = tr; pcInc = inc; PcOrTR = sel; diLoadEn = di;
    mem_ready = (waits == 0);
    mem_rdata = (waits == 0) ? data : 8'hEE;
    @(negedge clk);
    chk("mem_addr", {19'd0, mem_addr}, {19'd0, addr});
    chk("mem_rd", {31'd0, mem_rd}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      if (stall) sc++;
      @(posedge clk); #1;
      if (i == waits - 1) begin
        mem_ready = 1; mem_rdata = data;
      end
      @(negedge clk);
    end
    if (stall) sc++;
    chk("stall_cycles", sc, waits);
    @(posedge clk); #1;
    idle_cmds();
  endtask

  task automatic jump();
    pcLoadEn = 1; pcInc = 1;
    @(posedge clk); #1;
    pcLoadEn = 0; pcInc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    rst = 1;
    idle_cmds();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc",    {19'd0, pc_out}, 32'd0);
    chk("rst_ir",    {24'd0, ir_out}, 32'd0);
    chk("rst_tr",    {24'd0, tr_out}, 32'd0);
    chk("rst_di",    {27'd0, DiToCU}, 32'd0);
    chk("rst_stall", {31'd0, stall},  32'd0);
    chk("rst_mem_rd",{31'd0, mem_rd}, 32'd0);
    chk("rst_berr",  {31'd0, bus_err},32'd0);
    @(posedge clk); #1;
    rst = 0;

    // 1: zero-wait IR fetch
    do_read(1, 0, 1, 1, 0, 8'hA5, 0, 13'h0000, '{8'hA5, 8'h00, 13'h0001, 5'h05, 1'b0});
    // 2: TR fetch with three wait states, PC bumps once
    do_read(0, 1, 1, 1, 0, 8'h3C, 3, 13'h0001, '{8'hA5, 8'h3C, 13'h0002, 5'h05, 1'b0});
    // 3: build IR=15/TR=80, jump with simultaneous pcInc
    do_read(1, 0, 1, 1, 0, 8'h15, 0, 13'h0002, '{8'h15, 8'h3C, 13'h0003, 5'h15, 1'b0});
    do_read(0, 1, 1, 1, 0, 8'h80, 1, 13'h0003, '{8'h15, 8'h80, 13'h0004, 5'h15, 1'b0});
    jump();
    @(negedge clk);
    chk("jump_pc", {19'd0, pc_out}, 32'h1580);
    @(posedge clk); #1;
    pcInc = 1;
    @(posedge clk); #1;
    pcInc = 0;
    @(negedge clk);
    chk("inc_alone_pc", {19'd0, pc_out}, 32'h1581);
    @(posedge clk); #1;
    do_read(0, 1, 0, 0, 0, 8'h80, 0, 13'h1580, '{8'h15, 8'h80, 13'h1581, 5'h15, 1'b0});
    // 4: reach 1FFF by jump, fetch with pcInc wraps; IR load beats diLoadEn
    do_read(1, 0, 1, 1, 0, 8'h1F, 0, 13'h1581, '{8'h1F, 8'h80, 13'h1582, 5'h1F, 1'b0});
    do_read(0, 1, 1, 1, 0, 8'hFF, 0, 13'h1582, '{8'h1F, 8'hFF, 13'h1583, 5'h1F, 1'b0});
    jump();
    @(negedge clk);
    chk("jump_pc_max", {19'd0, pc_out}, 32'h1FFF);
    @(posedge clk); #1;
    do_read(1, 0, 1, 1, 1, 8'h42, 0, 13'h1FFF, '{8'h42, 8'hFF, 13'h0000, 5'h02, 1'b0});

    // 5: reset during WAIT of an IR fetch
    irWriteEn = 1; pcInc = 1; PcOrTR = 1; mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1;
    idle_cmds();
    #1;
    chk("rstwait_ir",    {24'd0, ir_out}, 32'd0);
    chk("rstwait_pc",    {19'd0, pc_out}, 32'd0);
    chk("rstwait_stall", {31'd0, stall},  32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    do_read(1, 0, 1, 1, 0, 8'h77, 0, 13'h0000, '{8'h77, 8'h00, 13'h0001, 5'h17, 1'b0});

    // 6: memory never answers
    sc = 0;
    irWriteEn = 1; pcInc = 1; PcOrTR = 1; mem_ready = 0; mem_rdata = 8'hEE;
`ifdef FETCH_TIMEOUT_EN
    sb.push_back('{8'h00, 8'h00, 13'h0002, 5'h00, 1'b1});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      @(posedge clk); #1;
    end
    chk("timeout_stall_cycles", sc, 15);
    @(posedge clk); #1;
    idle_cmds();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);
    @(posedge clk); #1;
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall) sc++;
      @(posedge clk); #1;
    end
    chk("no_timeout_stall_cycles", sc, 20);
    chk("no_timeout_berr", {31'd0, bus_err}, 32'd0);
    sb.push_back('{8'h99, 8'h00, 13'h0002, 5'h19, 1'b0});
    mem_ready = 1; mem_rdata = 8'h99;
    @(negedge clk);
    chk("late_ready_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    idle_cmds();
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter stage feeding the multi-cycle controller.
- Owns PC, IR (first instruction byte), TR (second byte of 16-bit instructions) and DI (condition/jump field) and drives the memory read port.
- Decodes controller commands into memory reads and supplies IrToCU/DiToCU back to the controller.
- Adds wait-state handling: a `stall` output freezes the controller's state register while memory is not ready.

Parameters:
- AW, 13, PC / memory address width; jump target = {IR[4:0], TR[7:0]}.
- DW, 8, memory data width and IR/TR width.
- TIMEOUT, 15, maximum wait cycles before bus error; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pcInc  in  1  increment PC when the current read completes.
- PcOrTR  in  1  1: read address = PC; 0: read address = {IR[4:0],TR}.
- irWriteEn  in  1  read memory into IR.
- trWriteEn  in  1  read memory into TR.
- diLoadEn  in  1  load DI from IR[4:0]; no memory access.
- pcLoadEn  in  1  load PC with {IR[4:0],TR}.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory read data valid this cycle.
- mem_addr  out  AW  memory read address.
- mem_rd  out  1  memory read request.
- stall  out  1  hold controller state and commands.
- IrToCU  out  4  IR[7:4].
- DiToCU  out  5  DI register.
- ir_out  out  DW  IR to datapath.
- tr_out  out  DW  TR to datapath.
- pc_out  out  AW  current PC.
- bus_err  out  1  sticky timeout flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset (async, rst=1): PC, IR, TR, DI = 0; FSM = IDLE; wait count = 0; bus_err = 0. Combinational outputs then evaluate to mem_rd = 0 and stall = 0 with no commands asserted.
- Read command: `rd_cmd` = irWriteEn | trWriteEn.
- mem_rd = rd_cmd, combinational.
- mem_addr = PcOrTR ? PC : {IR[4:0],TR}, combinational.
- stall = rd_cmd & ~mem_ready, combinational.
- Controller holds all commands stable while stall=1.
- FSM states:
  - IDLE: if rd_cmd & mem_ready, complete this cycle (zero wait states), stay IDLE. If rd_cmd & ~mem_ready, go to WAIT with count = 1.
  - WAIT: count increments each cycle (saturating). On mem_ready, complete and go to IDLE, count = 0. If rd_cmd drops (illegal), return to IDLE without completing.
- Completion edge:
  - irWriteEn: IR <= mem_rdata and DI <= mem_rdata[4:0].
  - trWriteEn (without irWriteEn): TR <= mem_rdata.
  - Both asserted (illegal): only IR loads.
  - pcInc at completion: PC <= PC + 1, wrapping 2^AW-1 -> 0.
- pcInc without rd_cmd: increments at the next edge.
- pcInc with rd_cmd while not completing: PC holds (exactly one increment per access).
- pcLoadEn: PC <= {IR[4:0],TR} at the edge. Overrides a same-cycle pcInc. Never stalls.
- diLoadEn: DI <= IR[4:0] at the edge. Ignored if the same edge also loads IR (IR-completion value wins).
- Latency: IrToCU/ir_out valid the cycle after completion. Zero-wait read = 1 controller cycle; N wait states = N+1 cycles.
- Reset mid-WAIT: transaction abandoned, nothing loaded, PC unchanged from its reset value 0.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined: if the count in WAIT reaches TIMEOUT without mem_ready:
  - bus_err <= 1, sticky until rst;
  - the access is force-completed with mem_rdata treated as 0 (IR/TR load 0, pcInc applied);
  - FSM returns to IDLE and stall drops that cycle.
- Undefined: no counter-based abort; WAIT persists indefinitely; bus_err tied 0.

Test Plan:
1. Reset, then irWriteEn=1, PcOrTR=1, pcInc=1, mem_ready=1, mem_rdata=8'hA5 -> mem_addr=0, stall=0; next cycle IR=8'hA5, IrToCU=4'hA, DI=5'h05, PC=1.
2. Wait state: trWriteEn=1, PcOrTR=1, pcInc=1, mem_ready low 3 cycles then high with 8'h3C -> stall=1 for exactly 3 cycles; TR=8'h3C; PC increments once only.
3. Jump: IR=8'h15, TR=8'h80, pcLoadEn=1 with pcInc=1 same cycle -> PC=13'h1580 (load wins).
4. Wrap: PC=13'h1FFF, zero-wait fetch with pcInc -> PC=0.
5. Reset mid-wait: rst pulsed during WAIT of an IR fetch -> IR=0, PC=0, stall=0; a following zero-wait fetch works.
6. With FETCH_TIMEOUT_EN, TIMEOUT=15, mem_ready held 0 -> stall high 15 cycles, then bus_err=1, IR=0, PC+1. Without the macro -> stall remains 1, bus_err=0.
